// File: rtl/win_pkg.sv
// Shared definitions for the 3x3 window generator.
//   WIN_DATA_WIDTH : default pixel width.
//   WIN_TL..WIN_BR : window slot indices, row-major, top-left (oldest) to
//                    bottom-right (newest pixel).
//   col_w / row_w  : counter widths for a given image width / height.
package win_pkg;

   localparam int WIN_DATA_WIDTH = 8;
   localparam int WIN_SIZE       = 9;

   localparam int WIN_TL = 0;
   localparam int WIN_TC = 1;
   localparam int WIN_TR = 2;
   localparam int WIN_ML = 3;
   localparam int WIN_MC = 4;
   localparam int WIN_MR = 5;
   localparam int WIN_BL = 6;
   localparam int WIN_BC = 7;
   localparam int WIN_BR = 8;

   function automatic int col_w(input int img_width);
      return (img_width > 1) ? $clog2(img_width) : 1;
   endfunction

   function automatic int row_w(input int img_height);
      return (img_height > 1) ? $clog2(img_height) : 1;
   endfunction

endpackage

// File: rtl/line_buffer_8bits.sv
// Single-port line buffer, one image line deep.
// Read is asynchronous on addr, write happens on the rising edge, so a beat
// that reads and writes the same address sees the old contents
// (read-before-write). Contents are deliberately not reset.
// Ports:
//   clk     : clock
//   we      : write enable (one pixel beat)
//   addr    : column index
//   wr_data : value stored at addr on this beat
//   rd_data : value currently stored at addr
module line_buffer_8bits #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 640,
   parameter int ADDR_W     = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wr_data;
      end
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/window_gen_3x3_8bits.sv
// Streaming 3x3 neighbourhood generator feeding a 9-input median finder.
// Takes one raster-order pixel per in_valid beat, keeps the two previous
// lines in line buffers and presents the 3x3 window one clock after the beat
// that completes it. Only fully populated windows are emitted (no padding).
// Optional feature: define WIN_SOF_SYNC_EN to add in_sof, which forces the
// qualified pixel to row 0 / col 0.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid          : in_pixel carries the next raster pixel
//   in_sof            : (WIN_SOF_SYNC_EN only) start-of-frame marker
//   in_pixel          : input pixel
//   out_valid         : one-cycle strobe per completed window
//   pixel0..pixel8    : window, rows r-2 / r-1 / r, pixel8 newest
//   out_col, out_row  : coordinates of the window centre
module window_gen_3x3_8bits
   import win_pkg::*;
#(
   parameter int DATA_WIDTH = WIN_DATA_WIDTH,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
`ifdef WIN_SOF_SYNC_EN
   input  logic                               in_sof,
`endif
   input  logic [DATA_WIDTH-1:0]              in_pixel,
   output logic                               out_valid,
   output logic [DATA_WIDTH-1:0]              pixel0,
   output logic [DATA_WIDTH-1:0]              pixel1,
   output logic [DATA_WIDTH-1:0]              pixel2,
   output logic [DATA_WIDTH-1:0]              pixel3,
   output logic [DATA_WIDTH-1:0]              pixel4,
   output logic [DATA_WIDTH-1:0]              pixel5,
   output logic [DATA_WIDTH-1:0]              pixel6,
   output logic [DATA_WIDTH-1:0]              pixel7,
   output logic [DATA_WIDTH-1:0]              pixel8,
   output logic [col_w(IMG_WIDTH)-1:0]        out_col,
   output logic [row_w(IMG_HEIGHT)-1:0]       out_row
);

   localparam int COL_W = col_w(IMG_WIDTH);
   localparam int ROW_W = row_w(IMG_HEIGHT);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0]      col_p0;
   logic [ROW_W-1:0]      row_p0;
   logic [COL_W-1:0]      cur_col;
   logic [ROW_W-1:0]      cur_row;
   logic                  sof_beat;
   logic                  win_done;
   logic [DATA_WIDTH-1:0] lb0_rd;
   logic [DATA_WIDTH-1:0] lb1_rd;
   logic [DATA_WIDTH-1:0] win_p0 [WIN_SIZE];
   logic                  vld_p0;
   logic [COL_W-1:0]      ctr_col_p0;
   logic [ROW_W-1:0]      ctr_row_p0;

`ifdef WIN_SOF_SYNC_EN
   assign sof_beat = in_valid & in_sof;
`else
   assign sof_beat = 1'b0;
`endif

   // A start-of-frame beat overrides the counters for this very pixel, so the
   // line-buffer address and the valid decision already use column/row 0.
   assign cur_col  = sof_beat ? '0 : col_p0;
   assign cur_row  = sof_beat ? '0 : row_p0;
   assign win_done = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);

   // lb1 holds row r-1; its old content cascades into lb0 as row r-2.
   line_buffer_8bits #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_W     (COL_W)
   ) u_lb1 (
      .clk     (clk),
      .we      (in_valid),
      .addr    (cur_col),
      .wr_data (in_pixel),
      .rd_data (lb1_rd)
   );

   line_buffer_8bits #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_W     (COL_W)
   ) u_lb0 (
      .clk     (clk),
      .we      (in_valid),
      .addr    (cur_col),
      .wr_data (lb1_rd),
      .rd_data (lb0_rd)
   );

   // ---- stage p0: counters, window shift register, valid strobe ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_p0     <= '0;
         row_p0     <= '0;
         vld_p0     <= 1'b0;
         ctr_col_p0 <= '0;
         ctr_row_p0 <= '0;
         for (int i = 0; i < WIN_SIZE; i++) begin
            win_p0[i] <= '0;
         end
      end else begin
         vld_p0 <= in_valid && win_done;
         if (in_valid) begin
            if (cur_col == COL_LAST) begin
               col_p0 <= '0;
               row_p0 <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
            end else begin
               col_p0 <= cur_col + COL_W'(1);
               row_p0 <= cur_row;
            end

            if (win_done) begin
               ctr_col_p0 <= cur_col - COL_W'(1);
               ctr_row_p0 <= cur_row - ROW_W'(1);
            end

            // Every row shifts left; the incoming column enters on the right.
            // At the start of a line this flushes the previous line's columns.
            win_p0[WIN_TL] <= win_p0[WIN_TC];
            win_p0[WIN_TC] <= win_p0[WIN_TR];
            win_p0[WIN_TR] <= lb0_rd;
            win_p0[WIN_ML] <= win_p0[WIN_MC];
            win_p0[WIN_MC] <= win_p0[WIN_MR];
            win_p0[WIN_MR] <= lb1_rd;
            win_p0[WIN_BL] <= win_p0[WIN_BC];
            win_p0[WIN_BC] <= win_p0[WIN_BR];
            win_p0[WIN_BR] <= in_pixel;
         end
      end
   end

   assign out_valid = vld_p0;
   assign out_col   = ctr_col_p0;
   assign out_row   = ctr_row_p0;
   assign pixel0    = win_p0[WIN_TL];
   assign pixel1    = win_p0[WIN_TC];
   assign pixel2    = win_p0[WIN_TR];
   assign pixel3    = win_p0[WIN_ML];
   assign pixel4    = win_p0[WIN_MC];
   assign pixel5    = win_p0[WIN_MR];
   assign pixel6    = win_p0[WIN_BL];
   assign pixel7    = win_p0[WIN_BC];
   assign pixel8    = win_p0[WIN_BR];

endmodule

// File: tb/tb_window_gen_3x3_8bits.sv
// Directed bench for window_gen_3x3_8bits on a 4x4 image.
module tb_window_gen_3x3_8bits;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_pixel;
`ifdef WIN_SOF_SYNC_EN
   logic       in_sof;
`endif
   logic       out_valid;
   logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8;
   logic [1:0] out_col;
   logic [1:0] out_row;
   logic [71:0] win_obs;

   int n_cmp;
   int n_err;
   int strobes;

   window_gen_3x3_8bits #(
      .DATA_WIDTH (8),
      .IMG_WIDTH  (4),
      .IMG_HEIGHT (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
`ifdef WIN_SOF_SYNC_EN
      .in_sof    (in_sof),
`endif
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .pixel0    (pixel0),
      .pixel1    (pixel1),
      .pixel2    (pixel2),
      .pixel3    (pixel3),
      .pixel4    (pixel4),
      .pixel5    (pixel5),
      .pixel6    (pixel6),
      .pixel7    (pixel7),
      .pixel8    (pixel8),
      .out_col   (out_col),
      .out_row   (out_row)
   );

   assign win_obs = {pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hand-derived 4x4 geometry: window k has top-left pixel TL[k]; the nine
   // slots sit at these raster offsets from it.
   function automatic logic [71:0] win_exp(input int base, input int k);
      int tl [4];
      int offs [9];
      logic [71:0] w;
      tl   = '{0, 1, 4, 5};
      offs = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      w = '0;
      for (int i = 0; i < 9; i++) begin
         w[71-8*i -: 8] = 8'(base + tl[k] + offs[i]);
      end
      return w;
   endfunction

   function automatic logic [7:0] median9(input logic [71:0] w);
      logic [7:0] a [9];
      logic [7:0] t;
      for (int i = 0; i < 9; i++) a[i] = w[71-8*i -: 8];
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8 - i; j++) begin
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      return a[4];
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid"}, 72'(out_valid), 72'd0);
      chk({tag, "_window"}, win_obs, 72'd0);
      chk({tag, "_col"}, 72'(out_col), 72'd0);
      chk({tag, "_row"}, 72'(out_row), 72'd0);
   endtask

   // One pixel beat at raster index p, followed by 'gap' idle cycles.
   task automatic beat(input int p, input logic [7:0] pix, input bit sof,
                       input bit cnst, input int base, input int gap);
      bit          ev;
      int          k;
      logic [71:0] ew;
      ev = ((p % 4) >= 2) && ((p / 4) >= 2);
      k  = ((p / 4) - 2) * 2 + ((p % 4) - 2);
      ew = '0;
      @(negedge clk);
      in_valid = 1'b1;
      in_pixel = pix;
`ifdef WIN_SOF_SYNC_EN
      in_sof   = sof;
`else
      if (sof) $display("note: in_sof requested without WIN_SOF_SYNC_EN");
`endif
      @(posedge clk);
      #1;
      chk("out_valid", 72'(out_valid), 72'(ev));
      if (out_valid === 1'b1) strobes++;
      if (ev) begin
         ew = cnst ? {9{8'h01}} : win_exp(base, k);
         chk("window", win_obs, ew);
         chk("out_col", 72'(out_col), 72'((p % 4) - 1));
         chk("out_row", 72'(out_row), 72'((p / 4) - 1));
         if (cnst) chk("median", 72'(median9(win_obs)), 72'd1);
      end
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         in_valid = 1'b0;
`ifdef WIN_SOF_SYNC_EN
         in_sof   = 1'b0;
`endif
         @(posedge clk);
         #1;
         chk("gap_valid", 72'(out_valid), 72'd0);
         if (ev) chk("gap_hold", win_obs, ew);
      end
   endtask

   task automatic frame(input int base, input bit cnst, input int gap, input bit sof_first);
      strobes = 0;
      for (int p = 0; p < 16; p++) begin
         beat(p, cnst ? 8'd1 : 8'(base + p), sof_first && (p == 0), cnst, base, gap);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
`ifdef WIN_SOF_SYNC_EN
      in_sof   = 1'b0;
`endif
      @(posedge clk);
      #1;
      chk("idle_valid", 72'(out_valid), 72'd0);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      strobes  = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_pixel = '0;
`ifdef WIN_SOF_SYNC_EN
      in_sof   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: continuous frame 0..15
      frame(0, 1'b0, 0, 1'b0);
      idle();
      chk("s1_strobes", 72'(strobes), 72'd4);

      // 2: three idle cycles after every pixel
      frame(0, 1'b0, 3, 1'b0);
      idle();
      chk("s2_strobes", 72'(strobes), 72'd4);

      // 3: two frames back to back
      frame(0, 1'b0, 0, 1'b0);
      chk("s3a_strobes", 72'(strobes), 72'd4);
      frame(100, 1'b0, 0, 1'b0);
      idle();
      chk("s3b_strobes", 72'(strobes), 72'd4);

      // 4: asynchronous reset after pixel 9, then a clean refeed
      for (int p = 0; p < 10; p++) beat(p, 8'(p), 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      frame(0, 1'b0, 0, 1'b0);
      idle();
      chk("s4_strobes", 72'(strobes), 72'd4);

      // 5: constant 1 on every pixel
      frame(0, 1'b1, 0, 1'b0);
      idle();
      chk("s5_strobes", 72'(strobes), 72'd4);

`ifdef WIN_SOF_SYNC_EN
      // 6: seven junk pixels, then a frame marked with in_sof on pixel 0
      for (int j = 0; j < 7; j++) beat(j, 8'(200 + j), 1'b0, 1'b0, 0, 0);
      frame(0, 1'b0, 0, 1'b1);
      idle();
      chk("s6_strobes", 72'(strobes), 72'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
